// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and mode constants for seq_accum
package seq_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_ACC = 1'b1;
endpackage

// File: rtl/seq_add_core.sv
// seq_add_core: acc+x+y with sticky carry, saturating when SEQ_ACCUM_SAT_EN is defined
module seq_add_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH+1:0] total;
  // three-operand sum; any bit above WIDTH-1 means one of the two additions carried out
  always_comb begin
    total = {2'b00, acc} + {2'b00, x} + {2'b00, y};
    carry = ci | (|total[WIDTH+1:WIDTH]);
`ifdef SEQ_ACCUM_SAT_EN
    sum = carry ? {WIDTH{1'b1}} : total[WIDTH-1:0];
`else
    sum = total[WIDTH-1:0];
`endif
  end
endmodule

// File: rtl/seq_accum.sv
// seq_accum: handshaked single-add / multi-beat accumulator (optional saturation via SEQ_ACCUM_SAT_EN)
module seq_accum
  import seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 operand_a,
  input  logic [WIDTH-1:0]                 operand_b,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 result,
  output logic                             overflow,
  output logic [$clog2(MAX_BEATS+1)-1:0]   beat_cnt
);
  localparam int CW = $clog2(MAX_BEATS+1);
  state_t state, next;
  logic first, accept, done, carry_n;
  logic [CW-1:0] cnt_inc;
  logic [WIDTH-1:0] sum_n;
  assign first = state == S_IDLE;
  assign in_ready = state != S_OUT;
  assign out_valid = state == S_OUT;
  assign accept = in_valid & in_ready;
  assign cnt_inc = first ? CW'(1) : beat_cnt + 1'b1;
  assign done = in_last | (first & (mode == MODE_SINGLE)) | (cnt_inc == CW'(MAX_BEATS));
  seq_add_core #(.WIDTH(WIDTH)) u_add (
    .acc   (first ? {WIDTH{1'b0}} : result),
    .x     (operand_a),
    .y     (operand_b),
    .ci    (~first & overflow),
    .sum   (sum_n),
    .carry (carry_n)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= next;
  end
  // next state: drain on out_ready, otherwise advance on an accepted beat
  always_comb begin
    next = state;
    next = (state == S_OUT) ? (out_ready ? S_IDLE : S_OUT) : accept ? (done ? S_OUT : S_ACC) : state;
  end
  // partial sum, sticky overflow and beat count; a first beat restarts all three
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      overflow <= 1'b0;
      beat_cnt <= '0;
    end else if (accept) begin
      result <= sum_n;
      overflow <= carry_n;
      beat_cnt <= cnt_inc;
    end
  end
endmodule

// File: tb/tb_seq_accum.sv
// tb_seq_accum: directed self-checking bench for seq_accum (WIDTH=4, MAX_BEATS=4)
module tb_seq_accum;
  logic clk = 1'b0;
  logic rst, mode, in_valid, in_ready, in_last, out_valid, out_ready, overflow;
  logic [3:0] operand_a, operand_b, result;
  logic [2:0] beat_cnt;
  int checks = 0;
  int errors = 0;
  seq_accum #(.WIDTH(4), .MAX_BEATS(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .operand_a(operand_a), .operand_b(operand_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .beat_cnt(beat_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic l, input logic m);
    in_valid = 1'b1;
    operand_a = a;
    operand_b = b;
    in_last = l;
    mode = m;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic chk_out(input string tag, input logic [3:0] r, input logic o, input logic [2:0] c);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_result"}, result, r);
    chk({tag, "_ovf"}, overflow, o);
    chk({tag, "_cnt"}, beat_cnt, c);
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_result"}, result, 4'd0);
    chk({tag, "_ovf"}, overflow, 1'b0);
    chk({tag, "_cnt"}, beat_cnt, 3'd0);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_ready"}, in_ready, 1'b1);
  endtask
  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    operand_a = '0; operand_b = '0;
    tick(); tick();
    chk_rst("in_rst");
    rst = 1'b0;
    tick();
    chk_rst("post_rst");
    beat(4'd3, 4'd4, 1'b0, 1'b0);
    chk_out("single_3_4", 4'd7, 1'b0, 3'd1);
    chk("single_busy", in_ready, 1'b0);
    tick();
    chk("single_drain", out_valid, 1'b0);
    beat(4'd9, 4'd8, 1'b0, 1'b0);
`ifdef SEQ_ACCUM_SAT_EN
    chk_out("single_9_8", 4'd15, 1'b1, 3'd1);
`else
    chk_out("single_9_8", 4'd1, 1'b1, 3'd1);
`endif
    tick();
    beat(4'd1, 4'd2, 1'b0, 1'b1);
    chk("acc_b1_valid", out_valid, 1'b0);
    chk("acc_b1_ready", in_ready, 1'b1);
    tick();
    chk("acc_hold_result", result, 4'd3);
    beat(4'd3, 4'd0, 1'b0, 1'b0);
    chk("acc_mode_ignored", out_valid, 1'b0);
    beat(4'd2, 4'd2, 1'b1, 1'b0);
    chk_out("acc_three", 4'd10, 1'b0, 3'd3);
    tick();
    for (int i = 0; i < 3; i++) beat(4'd1, 4'd1, 1'b0, 1'b1);
    chk("max_b3_valid", out_valid, 1'b0);
    out_ready = 1'b0;
    beat(4'd1, 4'd1, 1'b0, 1'b1);
    chk_out("max_beats", 4'd8, 1'b0, 3'd4);
    in_valid = 1'b1; operand_a = 4'd1; operand_b = 4'd1; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_ready", in_ready, 1'b0);
      chk("stall_result", result, 4'd8);
      chk("stall_cnt", beat_cnt, 3'd4);
    end
    out_ready = 1'b1;
    tick();
    chk("drain_idle_valid", out_valid, 1'b0);
    chk("drain_idle_ready", in_ready, 1'b1);
    chk("drain_no_accept", beat_cnt, 3'd4);
    tick();
    in_valid = 1'b0;
    chk("fifth_new_cnt", beat_cnt, 3'd1);
    chk("fifth_new_result", result, 4'd2);
    chk("fifth_in_acc", out_valid, 1'b0);
    beat(4'd0, 4'd0, 1'b1, 1'b1);
    chk_out("fifth_done", 4'd2, 1'b0, 3'd2);
    tick();
    beat(4'd2, 4'd3, 1'b0, 1'b1);
    beat(4'd1, 4'd1, 1'b0, 1'b1);
    rst = 1'b1; in_valid = 1'b1; in_last = 1'b1;
    tick();
    chk_rst("mid_rst");
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk_rst("mid_post_rst");
    beat(4'd5, 4'd5, 1'b0, 1'b0);
    chk_out("after_rst", 4'd10, 1'b0, 3'd1);
    tick();
    beat(4'd15, 4'd1, 1'b0, 1'b1);
    beat(4'd0, 4'd0, 1'b1, 1'b1);
`ifdef SEQ_ACCUM_SAT_EN
    chk_out("sticky", 4'd15, 1'b1, 3'd2);
`else
    chk_out("sticky", 4'd0, 1'b1, 3'd2);
`endif
    tick();
    beat(4'd1, 4'd1, 1'b0, 1'b0);
    chk_out("ovf_clear", 4'd2, 1'b0, 3'd1);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
